// File: rtl/pico_status_rx_if.sv
// Pico status link: 4-phase req/ack handshake plus the status word
// delivered to the pump controller.
interface pico_status_rx_if #(
  parameter int DATA_W = 4
);
  logic [DATA_W-1:0] data_in;
  logic              req_in;
  logic              ack_out;
  logic [DATA_W-1:0] status_out;
  logic              status_valid_out;
  logic              status_changed_out;
  logic              timeout_err_out;

  modport slave (
    input  data_in, req_in,
    output ack_out, status_out, status_valid_out, status_changed_out, timeout_err_out
  );

  modport master (
    output data_in, req_in,
    input  ack_out, status_out, status_valid_out, status_changed_out, timeout_err_out
  );
endinterface

// File: rtl/pico_status_rx.sv
// Receives the Pico's status word over an asynchronous 4-phase handshake,
// waits for stable data before acknowledging, and aborts stalled transfers.
module pico_status_rx #(
  parameter int DATA_W         = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic             clk,
  input  logic             reset,
  pico_status_rx_if.slave  bus
);
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_ACK, S_DRAIN} state_t;

  logic [SYNC_STAGES-1:0] r_req_sync;
  logic [DATA_W-1:0]      r_data_sync [SYNC_STAGES];
  logic                   w_req_s;
  logic [DATA_W-1:0]      w_data_s;

  state_t            r_state, w_state_next;
  logic [DATA_W-1:0] r_cap, w_cap_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic              r_ack, w_ack_next;
  logic [DATA_W-1:0] r_status, w_status_next;
  logic              r_valid, w_valid_next;
  logic              r_changed, w_changed_next;
  logic              r_err, w_err_next;
  logic              w_timeout;

  // Data bits get the same synchroniser depth as req so both settle together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_sync <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) r_data_sync[i] <= '0;
    end else begin
      r_req_sync[0]  <= bus.req_in;
      r_data_sync[0] <= bus.data_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_req_sync[i]  <= r_req_sync[i-1];
        r_data_sync[i] <= r_data_sync[i-1];
      end
    end
  end

  assign w_req_s   = r_req_sync[SYNC_STAGES-1];
  assign w_data_s  = r_data_sync[SYNC_STAGES-1];
  assign w_timeout = (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cap     <= '0;
      r_cnt     <= '0;
      r_ack     <= 1'b0;
      r_status  <= '0;
      r_valid   <= 1'b0;
      r_changed <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cap     <= w_cap_next;
      r_cnt     <= w_cnt_next;
      r_ack     <= w_ack_next;
      r_status  <= w_status_next;
      r_valid   <= w_valid_next;
      r_changed <= w_changed_next;
      r_err     <= w_err_next;
    end
  end

  // Normal exits are tested before the timeout so they win on the same cycle.
  always_comb begin
    w_state_next   = r_state;
    w_cap_next     = r_cap;
    w_cnt_next     = r_cnt;
    w_ack_next     = r_ack;
    w_status_next  = r_status;
    w_valid_next   = 1'b0;
    w_changed_next = 1'b0;
    w_err_next     = r_err;
    case (r_state)
      S_IDLE: begin
        if (w_req_s) begin
          w_cap_next   = w_data_s;
          w_cnt_next   = '0;
          w_state_next = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (!w_req_s) begin
          w_state_next = S_IDLE;
        end else if (w_data_s == r_cap) begin
          w_state_next   = S_ACK;
          w_ack_next     = 1'b1;
          w_status_next  = r_cap;
          w_valid_next   = 1'b1;
          w_changed_next = (r_cap != r_status);
          w_err_next     = 1'b0;
          w_cnt_next     = '0;
        end else if (w_timeout) begin
          w_state_next = S_DRAIN;
          w_ack_next   = 1'b0;
          w_err_next   = 1'b1;
        end else begin
          w_cap_next = w_data_s;
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_ACK: begin
        if (!w_req_s) begin
          w_state_next = S_IDLE;
          w_ack_next   = 1'b0;
        end else if (w_timeout) begin
          w_state_next = S_DRAIN;
          w_ack_next   = 1'b0;
          w_err_next   = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        w_ack_next = 1'b0;
        if (!w_req_s) w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
        w_ack_next   = 1'b0;
      end
    endcase
  end

  assign bus.ack_out            = r_ack;
  assign bus.status_out         = r_status;
  assign bus.status_valid_out   = r_valid;
  assign bus.status_changed_out = r_changed;
  assign bus.timeout_err_out    = r_err;
endmodule
